axi_lite_responder: RTL and testbench

AXI4-Lite responder (slave) that terminates AXI single-beat transactions inside the PL and exposes them as a small 32-bit register window. It is the far end of the 8088-to-AXI bus-capture path: the CPU-side capture logic issues AW/W/AR, and this block accepts them, updates read/write control registers and returns read-only status words. Per-register write pulses let downstream logic (video, PIT, keyboard glue) react to CPU writes.

---
 rtl/axi_lite_pkg.sv | 16 +
 rtl/axi_lite_reg_bank.sv | 80 ++++++++
 rtl/axi_lite_responder.sv | 147 ++++++++++++++
 tb/tb_axi_lite_responder.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared constants and helpers for the AXI4-Lite register responder.
//   RESP_OKAY / RESP_SLVERR : AXI response codes returned on B and R
//   index_width()           : number of word-index address bits for a window
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int index_width(input int num_words);
        return $clog2(num_words);
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_bank
// NUM_RW x 32-bit control registers with byte-strobe writes, a one-cycle
// write pulse per word, and a combinational read mux spanning the RW
// registers followed by the read-only status words.
// Ports:
//   AXI_CLK, RESETN   clock, asynchronous active-low reset
//   wr_en             commit a write to word wr_idx this edge (RW words only)
//   wr_idx            word index of the write
//   wr_data, wr_strb  write data and byte-lane enables
//   rd_idx            word index presented to the read mux
//   status_in         read-only words, packed 32 bits per word
//   reg_q             current RW register contents, packed 32 bits per word
//   reg_wr            one-cycle pulse per word committed on the previous edge
//   rd_word           combinational read-mux output for rd_idx
// ---------------------------------------------------------------------------
module axi_lite_reg_bank
    import axi_lite_pkg::*;
#(
    parameter int NUM_RW = 8,
    parameter int NUM_RO = 8,
    localparam int IW    = index_width(NUM_RW + NUM_RO)
) (
    input  logic                AXI_CLK,
    input  logic                RESETN,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [31:0]         wr_data,
    input  logic [3:0]          wr_strb,
    input  logic [IW-1:0]       rd_idx,
    input  logic [32*NUM_RO-1:0] status_in,
    output logic [32*NUM_RW-1:0] reg_q,
    output logic [NUM_RW-1:0]   reg_wr,
    output logic [31:0]         rd_word
);

    logic [31:0] mem [NUM_RW];

    // The pulse fires even when wr_strb is zero: downstream logic treats any
    // accepted CPU write as an event, whether or not bytes changed.
    always_ff @(posedge AXI_CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < NUM_RW; i++) begin
                mem[i] <= '0;
            end
            reg_wr <= '0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                reg_wr[i] <= wr_en && (wr_idx == IW'(i));
                if (wr_en && (wr_idx == IW'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            mem[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_q
        assign reg_q[32*g +: 32] = mem[g];
    end

    // Status words sit directly above the RW words in the index space.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_word = mem[i];
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (rd_idx == IW'(NUM_RW + j)) begin
                rd_word = status_in[32*j +: 32];
            end
        end
    end

endmodule

// File: rtl/axi_lite_responder.sv
// ---------------------------------------------------------------------------
// axi_lite_responder
// AXI4-Lite slave terminating single-beat transactions from the 8088 bus
// capture path into a 32-bit register window: NUM_RW control registers
// followed by NUM_RO read-only status words.
// Ports:
//   AXI_CLK, RESETN                 clock, asynchronous active-low reset
//   AXI_aw* / AXI_w* / AXI_b*       write address, write data, write response
//   AXI_ar* / AXI_r*                read address, read data
//   reg_q                           current RW register contents
//   reg_wr                          one-cycle pulse per committed RW word
//   status_in                       read-only words, sampled at AR handshake
// ---------------------------------------------------------------------------
module axi_lite_responder
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_RW     = 8,
    parameter int NUM_RO     = 8
) (
    input  logic                  AXI_CLK,
    input  logic                  RESETN,
    input  logic [ADDR_WIDTH-1:0] AXI_awaddr,
    input  logic                  AXI_awvalid,
    output logic                  AXI_awready,
    input  logic [31:0]           AXI_wdata,
    input  logic [3:0]            AXI_wstrb,
    input  logic                  AXI_wvalid,
    output logic                  AXI_wready,
    output logic [1:0]            AXI_bresp,
    output logic                  AXI_bvalid,
    input  logic                  AXI_bready,
    input  logic [ADDR_WIDTH-1:0] AXI_araddr,
    input  logic                  AXI_arvalid,
    output logic                  AXI_arready,
    output logic [31:0]           AXI_rdata,
    output logic [1:0]            AXI_rresp,
    output logic                  AXI_rvalid,
    input  logic                  AXI_rready,
    output logic [32*NUM_RW-1:0]  reg_q,
    output logic [NUM_RW-1:0]     reg_wr,
    input  logic [32*NUM_RO-1:0]  status_in
);

    localparam int IW = index_width(NUM_RW + NUM_RO);

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic [IW-1:0]         aw_idx;
    logic [IW-1:0]         ar_idx;
    logic                  aw_oor;
    logic                  ar_oor;
    logic                  aw_is_rw;
    logic                  commit;
    logic                  ar_hs;
    logic [31:0]           rd_word;
    logic                  unused_addr_bits;

    // Byte offset within a word carries no meaning in this window.
    assign unused_addr_bits = ^{aw_addr_q[1:0], AXI_araddr[1:0]};

    assign aw_idx   = aw_addr_q[IW+1:2];
    assign ar_idx   = AXI_araddr[IW+1:2];
    assign aw_oor   = (aw_addr_q >> (IW + 2)) != '0;
    assign ar_oor   = (AXI_araddr >> (IW + 2)) != '0;
    assign aw_is_rw = !aw_oor && (aw_idx < IW'(NUM_RW));

    // Both ready lines drop while a B response is outstanding, so a stalled
    // master cannot queue a second write behind the unacknowledged one.
    assign AXI_awready = !aw_held && !AXI_bvalid;
    assign AXI_wready  = !w_held && !AXI_bvalid;
    assign AXI_arready = !AXI_rvalid;

    assign commit = aw_held && w_held && !AXI_bvalid;
    assign ar_hs  = AXI_arvalid && AXI_arready;

    // AW and W are captured independently in either order; the write
    // commits the edge after both holding registers are full.
    always_ff @(posedge AXI_CLK or negedge RESETN) begin
        if (!RESETN) begin
            aw_held    <= 1'b0;
            aw_addr_q  <= '0;
            w_held     <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            AXI_bvalid <= 1'b0;
            AXI_bresp  <= RESP_OKAY;
        end else begin
            if (AXI_awvalid && AXI_awready) begin
                aw_held   <= 1'b1;
                aw_addr_q <= AXI_awaddr;
            end
            if (AXI_wvalid && AXI_wready) begin
                w_held   <= 1'b1;
                w_data_q <= AXI_wdata;
                w_strb_q <= AXI_wstrb;
            end
            if (commit) begin
                aw_held    <= 1'b0;
                w_held     <= 1'b0;
                AXI_bvalid <= 1'b1;
                AXI_bresp  <= aw_is_rw ? RESP_OKAY : RESP_SLVERR;
            end else if (AXI_bvalid && AXI_bready) begin
                AXI_bvalid <= 1'b0;
            end
        end
    end

    // Read data is registered at the AR handshake, so a write committing on
    // the same edge is not yet visible to that read.
    always_ff @(posedge AXI_CLK or negedge RESETN) begin
        if (!RESETN) begin
            AXI_rvalid <= 1'b0;
            AXI_rdata  <= '0;
            AXI_rresp  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                AXI_rvalid <= 1'b1;
                AXI_rdata  <= ar_oor ? 32'h0 : rd_word;
                AXI_rresp  <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (AXI_rvalid && AXI_rready) begin
                AXI_rvalid <= 1'b0;
            end
        end
    end

    axi_lite_reg_bank #(
        .NUM_RW (NUM_RW),
        .NUM_RO (NUM_RO)
    ) u_reg_bank (
        .AXI_CLK   (AXI_CLK),
        .RESETN    (RESETN),
        .wr_en     (commit && aw_is_rw),
        .wr_idx    (aw_idx),
        .wr_data   (w_data_q),
        .wr_strb   (w_strb_q),
        .rd_idx    (ar_idx),
        .status_in (status_in),
        .reg_q     (reg_q),
        .reg_wr    (reg_wr),
        .rd_word   (rd_word)
    );

endmodule

// File: tb/tb_axi_lite_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_responder
// Self-checking bench for axi_lite_responder: directed scenarios followed
// by randomized reads and writes, compared against an array-based model of
// the register window.
// ---------------------------------------------------------------------------
module tb_axi_lite_responder;
    import axi_lite_pkg::*;

    localparam int ADDR_WIDTH = 32;
    localparam int NUM_RW     = 8;
    localparam int NUM_RO     = 8;
    localparam int TIMEOUT    = 50;

    logic                  AXI_CLK = 1'b0;
    logic                  RESETN  = 1'b0;
    logic [ADDR_WIDTH-1:0] AXI_awaddr  = '0;
    logic                  AXI_awvalid = 1'b0;
    logic                  AXI_awready;
    logic [31:0]           AXI_wdata   = '0;
    logic [3:0]            AXI_wstrb   = '0;
    logic                  AXI_wvalid  = 1'b0;
    logic                  AXI_wready;
    logic [1:0]            AXI_bresp;
    logic                  AXI_bvalid;
    logic                  AXI_bready  = 1'b0;
    logic [ADDR_WIDTH-1:0] AXI_araddr  = '0;
    logic                  AXI_arvalid = 1'b0;
    logic                  AXI_arready;
    logic [31:0]           AXI_rdata;
    logic [1:0]            AXI_rresp;
    logic                  AXI_rvalid;
    logic                  AXI_rready  = 1'b0;
    logic [32*NUM_RW-1:0]  reg_q;
    logic [NUM_RW-1:0]     reg_wr;
    logic [32*NUM_RO-1:0]  status_in = '0;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] modelRw [NUM_RW];
    logic [31:0] modelRo [NUM_RO];

    logic [31:0]       lastData;
    logic [1:0]        lastResp;
    logic [NUM_RW-1:0] lastPulse;

    always #5 AXI_CLK = ~AXI_CLK;

    axi_lite_responder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RW     (NUM_RW),
        .NUM_RO     (NUM_RO)
    ) dut (
        .AXI_CLK     (AXI_CLK),
        .RESETN      (RESETN),
        .AXI_awaddr  (AXI_awaddr),
        .AXI_awvalid (AXI_awvalid),
        .AXI_awready (AXI_awready),
        .AXI_wdata   (AXI_wdata),
        .AXI_wstrb   (AXI_wstrb),
        .AXI_wvalid  (AXI_wvalid),
        .AXI_wready  (AXI_wready),
        .AXI_bresp   (AXI_bresp),
        .AXI_bvalid  (AXI_bvalid),
        .AXI_bready  (AXI_bready),
        .AXI_araddr  (AXI_araddr),
        .AXI_arvalid (AXI_arvalid),
        .AXI_arready (AXI_arready),
        .AXI_rdata   (AXI_rdata),
        .AXI_rresp   (AXI_rresp),
        .AXI_rvalid  (AXI_rvalid),
        .AXI_rready  (AXI_rready),
        .reg_q       (reg_q),
        .reg_wr      (reg_wr),
        .status_in   (status_in)
    );

    // Hard stop in case a wait loop is somehow bypassed.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [32*NUM_RW-1:0] packRw();
        logic [32*NUM_RW-1:0] v;
        for (int i = 0; i < NUM_RW; i++) v[32*i +: 32] = modelRw[i];
        return v;
    endfunction

    task automatic syncStatus();
        for (int j = 0; j < NUM_RO; j++) status_in[32*j +: 32] = modelRo[j];
    endtask

    // Reference model: byte address window of 4*(NUM_RW+NUM_RO) bytes, RW
    // words first; anything at or above the window end is an error.
    function automatic void modelWrite(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb, output logic [1:0] resp,
                                       output logic [NUM_RW-1:0] pulse);
        int idx;
        pulse = '0;
        if (addr < 32'(4 * NUM_RW)) begin
            idx = int'(addr / 4);
            for (int b = 0; b < 4; b++)
                if (strb[b]) modelRw[idx][8*b +: 8] = data[8*b +: 8];
            pulse[idx] = 1'b1;
            resp = RESP_OKAY;
        end else begin
            resp = RESP_SLVERR;
        end
    endfunction

    function automatic void modelRead(input logic [31:0] addr, output logic [31:0] data,
                                      output logic [1:0] resp);
        int idx;
        if (addr < 32'(4 * (NUM_RW + NUM_RO))) begin
            idx  = int'(addr / 4);
            data = (idx < NUM_RW) ? modelRw[idx] : modelRo[idx - NUM_RW];
            resp = RESP_OKAY;
        end else begin
            data = 32'h0;
            resp = RESP_SLVERR;
        end
    endfunction

    function automatic logic sigOf(input int which);
        case (which)
            0:       return AXI_awready;
            1:       return AXI_wready;
            2:       return AXI_arready;
            3:       return AXI_bvalid;
            4:       return AXI_rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitFor(input string tag, input int which);
        int n = 0;
        while (!sigOf(which) && n < TIMEOUT) begin
            @(posedge AXI_CLK); #1;
            n++;
        end
        checkOutput({tag, "_wait"}, 256'(sigOf(which)), 256'(1));
    endtask

    task automatic sendAw(input logic [31:0] addr);
        AXI_awaddr  = addr;
        AXI_awvalid = 1'b1;
        waitFor("awready", 0);
        @(posedge AXI_CLK); #1;
        AXI_awvalid = 1'b0;
    endtask

    task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
        AXI_wdata  = data;
        AXI_wstrb  = strb;
        AXI_wvalid = 1'b1;
        waitFor("wready", 1);
        @(posedge AXI_CLK); #1;
        AXI_wvalid = 1'b0;
    endtask

    // One full transaction; results land in lastData/lastResp/lastPulse.
    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input int gap, input bit wFirst);
        if (isWrite) begin
            if (gap == 0) begin
                AXI_awaddr  = addr;
                AXI_awvalid = 1'b1;
                AXI_wdata   = data;
                AXI_wstrb   = strb;
                AXI_wvalid  = 1'b1;
                waitFor("awready", 0);
                waitFor("wready", 1);
                @(posedge AXI_CLK); #1;
                AXI_awvalid = 1'b0;
                AXI_wvalid  = 1'b0;
            end else if (wFirst) begin
                sendW(data, strb);
                repeat (gap) begin @(posedge AXI_CLK); #1; end
                sendAw(addr);
            end else begin
                sendAw(addr);
                repeat (gap) begin @(posedge AXI_CLK); #1; end
                sendW(data, strb);
            end
            waitFor("bvalid", 3);
            lastPulse  = reg_wr;
            lastResp   = AXI_bresp;
            AXI_bready = 1'b1;
            @(posedge AXI_CLK); #1;
            AXI_bready = 1'b0;
            checkOutput("reg_wr_one_cycle", 256'(reg_wr), 256'(0));
            checkOutput("bvalid_cleared", 256'(AXI_bvalid), 256'(0));
        end else begin
            AXI_araddr  = addr;
            AXI_arvalid = 1'b1;
            waitFor("arready", 2);
            @(posedge AXI_CLK); #1;
            AXI_arvalid = 1'b0;
            waitFor("rvalid", 4);
            lastData   = AXI_rdata;
            lastResp   = AXI_rresp;
            AXI_rready = 1'b1;
            @(posedge AXI_CLK); #1;
            AXI_rready = 1'b0;
            checkOutput("rvalid_cleared", 256'(AXI_rvalid), 256'(0));
        end
    endtask

    task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int gap, input bit wFirst);
        logic [1:0]        expResp;
        logic [NUM_RW-1:0] expPulse;
        applyStimulus(1'b1, addr, data, strb, gap, wFirst);
        modelWrite(addr, data, strb, expResp, expPulse);
        checkOutput({tag, "_bresp"}, 256'(lastResp), 256'(expResp));
        checkOutput({tag, "_reg_wr"}, 256'(lastPulse), 256'(expPulse));
        checkOutput({tag, "_reg_q"}, 256'(reg_q), 256'(packRw()));
    endtask

    task automatic doRead(input string tag, input logic [31:0] addr);
        logic [31:0] expData;
        logic [1:0]  expResp;
        applyStimulus(1'b0, addr, 32'h0, 4'h0, 0, 1'b0);
        modelRead(addr, expData, expResp);
        checkOutput({tag, "_rdata"}, 256'(lastData), 256'(expData));
        checkOutput({tag, "_rresp"}, 256'(lastResp), 256'(expResp));
    endtask

    initial begin
        logic [31:0] oldVal;
        logic [31:0] a;
        logic [1:0]  dummyResp;
        int          sel;

        for (int i = 0; i < NUM_RW; i++) modelRw[i] = '0;
        for (int j = 0; j < NUM_RO; j++) modelRo[j] = 32'h5000_0000 + 32'(j);
        syncStatus();

        // Reset state.
        repeat (3) @(posedge AXI_CLK);
        #1;
        checkOutput("rst_bvalid", 256'(AXI_bvalid), 256'(0));
        checkOutput("rst_rvalid", 256'(AXI_rvalid), 256'(0));
        checkOutput("rst_reg_q", 256'(reg_q), 256'(0));
        checkOutput("rst_reg_wr", 256'(reg_wr), 256'(0));
        checkOutput("rst_rdata", 256'(AXI_rdata), 256'(0));
        checkOutput("rst_resps", 256'({AXI_bresp, AXI_rresp}), 256'(0));
        RESETN = 1'b1;
        @(posedge AXI_CLK); #1;
        checkOutput("rel_readies", 256'({AXI_awready, AXI_wready, AXI_arready}), 256'(3'b111));

        // AW at cycle 0, W three cycles later.
        doWrite("w1_full", 32'h04, 32'hDEADBEEF, 4'b1111, 2, 1'b0);
        checkOutput("w1_word1", 256'(reg_q[63:32]), 256'(32'hDEADBEEF));
        checkOutput("w1_pulse", 256'(lastPulse), 256'(8'b0000_0010));

        // Partial byte strobe.
        doWrite("w1_partial", 32'h04, 32'h11223344, 4'b0101, 0, 1'b0);
        checkOutput("w1_merged", 256'(reg_q[63:32]), 256'(32'hDE22BE44));

        // Status word read and write to read-only word.
        modelRo[0] = 32'hCAFE0001;
        syncStatus();
        doRead("ro_read", 32'h20);
        checkOutput("ro_read_val", 256'(lastData), 256'(32'hCAFE0001));
        doWrite("ro_write", 32'h20, 32'h0BAD0BAD, 4'hF, 1, 1'b1);
        checkOutput("ro_write_slverr", 256'(lastResp), 256'(RESP_SLVERR));

        // Out of range.
        doRead("oor_read", 32'h100);
        doWrite("oor_write", 32'h100, 32'hFFFFFFFF, 4'hF, 0, 1'b0);

        // Zero strobe still pulses; W-first and simultaneous orderings.
        doWrite("zero_strb", 32'h08, 32'h77777777, 4'b0000, 0, 1'b0);
        doWrite("w_first", 32'h0C, 32'h01020304, 4'hF, 3, 1'b1);
        doWrite("low_bits", 32'h1B, 32'hA0B0C0D0, 4'b1100, 1, 1'b0);

        // Commit and same-word read on one edge, then B held for 10 cycles.
        modelRead(32'h0C, oldVal, dummyResp);
        AXI_awaddr  = 32'h0C;
        AXI_awvalid = 1'b1;
        AXI_wdata   = 32'hA5A50F0F;
        AXI_wstrb   = 4'hF;
        AXI_wvalid  = 1'b1;
        @(posedge AXI_CLK); #1;
        AXI_awvalid = 1'b0;
        AXI_wvalid  = 1'b0;
        AXI_araddr  = 32'h0C;
        AXI_arvalid = 1'b1;
        @(posedge AXI_CLK); #1;
        AXI_arvalid = 1'b0;
        modelWrite(32'h0C, 32'hA5A50F0F, 4'hF, lastResp, lastPulse);
        checkOutput("same_edge_rvalid", 256'(AXI_rvalid), 256'(1));
        checkOutput("same_edge_old", 256'(AXI_rdata), 256'(oldVal));
        checkOutput("same_edge_bvalid", 256'(AXI_bvalid), 256'(1));
        AXI_rready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge AXI_CLK); #1;
            AXI_rready = 1'b0;
            checkOutput("hold_b", 256'({AXI_bvalid, AXI_bresp, AXI_awready, AXI_wready}),
                        256'({1'b1, RESP_OKAY, 1'b0, 1'b0}));
        end
        doRead("after_commit", 32'h0C);
        checkOutput("after_commit_new", 256'(lastData), 256'(32'hA5A50F0F));
        AXI_bready = 1'b1;
        @(posedge AXI_CLK); #1;
        AXI_bready = 1'b0;
        checkOutput("hold_b_release", 256'(AXI_bvalid), 256'(0));

        // R held while a second AR waits.
        AXI_araddr  = 32'h24;
        AXI_arvalid = 1'b1;
        @(posedge AXI_CLK); #1;
        AXI_araddr = 32'h04;
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_r", 256'({AXI_rvalid, AXI_arready, AXI_rdata}),
                        256'({1'b1, 1'b0, modelRo[1]}));
            @(posedge AXI_CLK); #1;
        end
        AXI_rready = 1'b1;
        @(posedge AXI_CLK); #1;
        AXI_rready = 1'b0;
        @(posedge AXI_CLK); #1;
        AXI_arvalid = 1'b0;
        checkOutput("queued_ar_data", 256'({AXI_rvalid, AXI_rdata}), 256'({1'b1, modelRw[1]}));
        AXI_rready = 1'b1;
        @(posedge AXI_CLK); #1;
        AXI_rready = 1'b0;

        // Reset with an AW held: the AW must be forgotten.
        sendAw(32'h10);
        RESETN = 1'b0;
        for (int i = 0; i < NUM_RW; i++) modelRw[i] = '0;
        @(posedge AXI_CLK); #1;
        RESETN = 1'b1;
        checkOutput("midrst_reg_q", 256'(reg_q), 256'(0));
        sendW(32'h12345678, 4'hF);
        repeat (3) begin @(posedge AXI_CLK); #1; end
        checkOutput("midrst_no_b", 256'({AXI_bvalid, AXI_wready}), 256'(0));
        sendAw(32'h14);
        waitFor("midrst_bvalid", 3);
        modelWrite(32'h14, 32'h12345678, 4'hF, lastResp, lastPulse);
        checkOutput("midrst_reg_q_new", 256'(reg_q), 256'(packRw()));
        AXI_bready = 1'b1;
        @(posedge AXI_CLK); #1;
        AXI_bready = 1'b0;

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < NUM_RO; j++) modelRo[j] = $urandom();
            syncStatus();
            sel = int'($urandom_range(0, 9));
            if (sel < 8) a = 32'($urandom_range(0, 63));
            else         a = $urandom() | 32'h0000_0100;
            if ($urandom_range(0, 1) == 1)
                doWrite("rnd_wr", a, $urandom(), 4'($urandom_range(0, 15)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            else
                doRead("rnd_rd", a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
